// File: rtl/croc_prog_obi_demux.sv
// rtl/croc_prog_obi_demux.sv - runtime-programmable OBI address demux with internal error subordinate
// Optional LOCK register at 0x104 is enabled by defining CROC_DEMUX_LOCK_EN.
package croc_pkg;
   typedef struct packed {
      logic        req;
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [3:0]  aid;
   } sbr_obi_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic [3:0]  rid;
      logic        err;
   } sbr_obi_r_chan_t;

   typedef struct packed {
      logic            gnt;
      logic            rvalid;
      sbr_obi_r_chan_t r;
   } sbr_obi_rsp_t;

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   } reg_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   } reg_rsp_t;

   typedef struct packed {
      logic [31:0] idx;
      logic [31:0] start_addr;
      logic [31:0] end_addr;
   } addr_map_rule_t;
endpackage

module croc_prog_obi_demux #(
   parameter int unsigned NumRules = 8,
   parameter int unsigned NumSbr   = 9,
   parameter int unsigned MaxTrans = 4,
   parameter croc_pkg::addr_map_rule_t [NumRules-1:0] DefaultMap = '0,
   parameter type obi_req_t = croc_pkg::sbr_obi_req_t,
   parameter type obi_rsp_t = croc_pkg::sbr_obi_rsp_t,
   parameter type reg_req_t = croc_pkg::reg_req_t,
   parameter type reg_rsp_t = croc_pkg::reg_rsp_t
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  obi_req_t mgr_req_i,
   output obi_rsp_t mgr_rsp_o,
   output obi_req_t sbr_req_o [NumSbr],
   input  obi_rsp_t sbr_rsp_i [NumSbr],
   input  reg_req_t reg_req_i,
   output reg_rsp_t reg_rsp_o
);

   localparam int unsigned CntW     = $clog2(MaxTrans + 1);
   localparam int unsigned RuleIdxW = (NumRules > 1) ? $clog2(NumRules) : 1;
   localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxTrans);
   localparam logic [4:0]      NumSbrW = 5'(NumSbr);
   localparam logic [31:0]     ErrData = 32'hBADC_AB1E;

   logic [31:0]         start_q [NumRules];
   logic [31:0]         start_d [NumRules];
   logic [31:0]         end_q   [NumRules];
   logic [31:0]         end_d   [NumRules];
   logic [3:0]          idx_q   [NumRules];
   logic [3:0]          idx_d   [NumRules];
   logic [NumRules-1:0] en_q, en_d;

   logic [3:0]      sel_q, sel_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            err_pend_q, err_pend_d;
   logic [3:0]      err_rid_q, err_rid_d;

   logic            accept, mgr_gnt, mgr_rvalid, handshake;
   logic            found;
   logic [3:0]      hit_idx;
   obi_rsp_t        rsp_mux;

   logic                rule_hit;
   logic [RuleIdxW-1:0] rsel;
   logic [1:0]          rword;
   logic                lock_q;

`ifdef CROC_DEMUX_LOCK_EN
   logic lock_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lock_q <= 1'b0;
      end else begin
         lock_q <= lock_d;
      end
   end
`else
   assign lock_q = 1'b0;
`endif

   function automatic logic [31:0] merge_bytes(logic [31:0] old_v, logic [31:0] new_v,
                                               logic [3:0] strb);
      logic [31:0] res;
      res = old_v;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
      end
      return res;
   endfunction

   // Three words per 16-byte rule slot; the fourth word and misaligned offsets are holes.
   assign rule_hit = (reg_req_i.addr < 32'(NumRules * 16)) &&
                     (reg_req_i.addr[1:0] == 2'd0) && (reg_req_i.addr[3:2] != 2'd3);
   assign rsel     = reg_req_i.addr[4 +: RuleIdxW];
   assign rword    = reg_req_i.addr[3:2];

   always_comb begin
      start_d = start_q;
      end_d   = end_q;
      idx_d   = idx_q;
      en_d    = en_q;
`ifdef CROC_DEMUX_LOCK_EN
      lock_d  = lock_q;
`endif
      reg_rsp_o = '0;
      if (reg_req_i.valid) begin
         reg_rsp_o.ready = 1'b1;
         if (rule_hit) begin
            case (rword)
               2'd0:    reg_rsp_o.rdata = start_q[rsel];
               2'd1:    reg_rsp_o.rdata = end_q[rsel];
               default: reg_rsp_o.rdata = {en_q[rsel], 27'd0, idx_q[rsel]};
            endcase
            if (reg_req_i.write) begin
               if (lock_q) begin
                  reg_rsp_o.error = 1'b1;
               end else begin
                  case (rword)
                     2'd0: start_d[rsel] = merge_bytes(start_q[rsel], reg_req_i.wdata,
                                                       reg_req_i.wstrb);
                     2'd1: end_d[rsel]   = merge_bytes(end_q[rsel], reg_req_i.wdata,
                                                       reg_req_i.wstrb);
                     default: begin
                        if (reg_req_i.wstrb[0]) idx_d[rsel] = reg_req_i.wdata[3:0];
                        if (reg_req_i.wstrb[3]) en_d[rsel]  = reg_req_i.wdata[31];
                     end
                  endcase
               end
            end
         end else if (reg_req_i.addr == 32'h100) begin
            reg_rsp_o.rdata = 32'(NumRules);
`ifdef CROC_DEMUX_LOCK_EN
         end else if (reg_req_i.addr == 32'h104) begin
            reg_rsp_o.rdata = {31'd0, lock_q};
            if (reg_req_i.write && reg_req_i.wstrb[0] && reg_req_i.wdata[0]) lock_d = 1'b1;
`endif
         end else begin
            reg_rsp_o.error = 1'b1;
         end
      end
   end

   // Lowest-index enabled rule wins; a winning rule with a bad IDX still routes to the error port.
   always_comb begin
      found   = 1'b0;
      hit_idx = '0;
      for (int i = 0; i < int'(NumRules); i++) begin
         if (!found && en_q[i] && (start_q[i] < end_q[i]) &&
             (mgr_req_i.addr >= start_q[i]) && (mgr_req_i.addr < end_q[i])) begin
            found   = 1'b1;
            hit_idx = idx_q[i];
         end
      end
      sel_d = '0;
      if (found && (hit_idx != 4'd0) && ({1'b0, hit_idx} < NumSbrW)) sel_d = hit_idx;
   end

   always_comb begin
      for (int i = 0; i < int'(NumSbr); i++) sbr_req_o[i] = '0;
      accept  = mgr_req_i.req &&
                ((cnt_q == '0) || ((sel_d == sel_q) && (cnt_q < MaxCnt)));
      mgr_gnt = 1'b0;
      if (accept) begin
         if (sel_d == 4'd0) begin
            mgr_gnt = !err_pend_q;
         end else begin
            sbr_req_o[sel_d] = mgr_req_i;
            mgr_gnt          = sbr_rsp_i[sel_d].gnt;
         end
      end
   end

   always_comb begin
      rsp_mux = '0;
      if (sel_q == 4'd0) begin
         rsp_mux.rvalid  = err_pend_q;
         rsp_mux.r.rdata = ErrData;
         rsp_mux.r.rid   = err_rid_q;
         rsp_mux.r.err   = 1'b1;
      end else begin
         rsp_mux = sbr_rsp_i[sel_q];
      end
      // Nothing outstanding means any rvalid seen here is stale and must not leak upstream.
      mgr_rvalid       = rsp_mux.rvalid && (cnt_q != '0);
      mgr_rsp_o        = rsp_mux;
      mgr_rsp_o.gnt    = mgr_gnt;
      mgr_rsp_o.rvalid = mgr_rvalid;
   end

   assign handshake = accept && mgr_gnt;

   always_comb begin
      cnt_d = cnt_q;
      if (handshake && !mgr_rvalid) begin
         cnt_d = cnt_q + CntW'(1);
      end else if (!handshake && mgr_rvalid) begin
         cnt_d = cnt_q - CntW'(1);
      end
      err_pend_d = handshake && (sel_d == 4'd0);
      err_rid_d  = err_rid_q;
      if (handshake && (sel_d == 4'd0)) err_rid_d = mgr_req_i.aid;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q      <= '0;
         sel_q      <= '0;
         err_pend_q <= 1'b0;
         err_rid_q  <= '0;
         for (int i = 0; i < int'(NumRules); i++) begin
            start_q[i] <= DefaultMap[i].start_addr;
            end_q[i]   <= DefaultMap[i].end_addr;
            idx_q[i]   <= DefaultMap[i].idx[3:0];
         end
         en_q <= '1;
      end else begin
         cnt_q      <= cnt_d;
         err_pend_q <= err_pend_d;
         err_rid_q  <= err_rid_d;
         if (handshake) sel_q <= sel_d;
         start_q <= start_d;
         end_q   <= end_d;
         idx_q   <= idx_d;
         en_q    <= en_d;
      end
   end

endmodule
